// File: rtl/load_fsm_pkg.sv
// Shared definitions for the LOAD/STORE/FETCH sequencers: register codes,
// sequencer state encoding and bus-control bit positions.
package load_fsm_pkg;

  localparam int unsigned REG_R0   = 0;
  localparam int unsigned REG_R1   = 1;
  localparam int unsigned REG_R2   = 2;
  localparam int unsigned REG_R3   = 3;
  localparam int unsigned REG_P0   = 4;
  localparam int unsigned REG_MAX  = 4;
  localparam int unsigned NUM_REGS = REG_MAX + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHK   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_RD    = 3'd3,
    ST_LATCH = 3'd4,
    ST_WB    = 3'd5,
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_e;

  localparam int unsigned CTL_MARIN  = 0;
  localparam int unsigned CTL_MDRFM  = 1;
  localparam int unsigned CTL_MDROUT = 2;
  localparam int unsigned CTL_EN     = 3;
  localparam int unsigned CTL_RW     = 4;
  localparam int unsigned CTL_W      = 5;

endpackage

// File: rtl/load_fsm_reg_sel_decoder.sv
// Register-select decoder: turns a register code into a gated one-hot enable
// and flags codes outside the register file.
module reg_sel_decoder
  import load_fsm_pkg::*;
#(
  parameter int SEL_W = 6
) (
  input  logic [SEL_W-1:0]    code_i,
  input  logic                en_i,
  output logic [NUM_REGS-1:0] onehot_o,
  output logic                illegal_o
);

  assign illegal_o = (code_i > SEL_W'(REG_MAX));

  // Illegal codes match no entry, so the one-hot stays all-zero for them.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (code_i == SEL_W'(i)) onehot_o[i] = en_i;
    end
  end

endmodule

// File: rtl/load_fsm.sv
// LOAD Ri,[Rj] sequencer: drives Rj onto the bus into MAR, reads memory into
// MDR, then writes MDR into Ri. Moore outputs decoded from the state register.
module load_fsm
  import load_fsm_pkg::*;
#(
  parameter int SEL_W    = 6,
  parameter int MEM_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             donefetch,
  input  logic [SEL_W-1:0] param_dst,
  input  logic [SEL_W-1:0] param_addr,
  output logic             R0OutEn,
  output logic             R1OutEn,
  output logic             R2OutEn,
  output logic             R3OutEn,
  output logic             P0OutEn,
  output logic             R0InEn,
  output logic             R1InEn,
  output logic             R2InEn,
  output logic             R3InEn,
  output logic             P0InEn,
  output logic             MARin,
  output logic             MDR_frommemin,
  output logic             MDRout,
  output logic             EN,
  output logic             RW,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     dst_q, addr_q;
  logic [3:0]           wait_q, wait_d;
  logic [NUM_REGS-1:0]  src_oh, dst_oh;
  logic                 src_ill, dst_ill;
  logic [CTL_W-1:0]     ctl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Codes are captured only on an accepted request, so the running op is immune to later changes.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start && !donefetch) begin
      dst_q  <= param_dst;
      addr_q <= param_addr;
    end
  end

  reg_sel_decoder #(.SEL_W(SEL_W)) u_src_dec (
    .code_i    (addr_q),
    .en_i      (state_q == ST_ADDR),
    .onehot_o  (src_oh),
    .illegal_o (src_ill)
  );

  reg_sel_decoder #(.SEL_W(SEL_W)) u_dst_dec (
    .code_i    (dst_q),
    .en_i      (state_q == ST_WB),
    .onehot_o  (dst_oh),
    .illegal_o (dst_ill)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    ctl     = '0;
    done    = 1'b0;
    err     = 1'b0;
    busy    = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CHK;
      ST_CHK:   state_d = (src_ill || dst_ill) ? ST_ERR : ST_ADDR;
      ST_ADDR: begin
        ctl[CTL_MARIN] = 1'b1;
        wait_d         = '0;
        state_d        = ST_RD;
      end
      ST_RD: begin
        ctl[CTL_EN] = 1'b1;
        ctl[CTL_RW] = 1'b1;
        if (wait_q == 4'(MEM_WAIT - 1)) state_d = ST_LATCH;
        else                            wait_d  = wait_q + 4'd1;
      end
      ST_LATCH: begin
        ctl[CTL_EN]    = 1'b1;
        ctl[CTL_RW]    = 1'b1;
        ctl[CTL_MDRFM] = 1'b1;
        state_d        = ST_WB;
      end
      ST_WB: begin
        ctl[CTL_MDROUT] = 1'b1;
        state_d         = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        err     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (donefetch) state_d = ST_IDLE;
  end

  assign R0OutEn       = src_oh[REG_R0];
  assign R1OutEn       = src_oh[REG_R1];
  assign R2OutEn       = src_oh[REG_R2];
  assign R3OutEn       = src_oh[REG_R3];
  assign P0OutEn       = src_oh[REG_P0];
  assign R0InEn        = dst_oh[REG_R0];
  assign R1InEn        = dst_oh[REG_R1];
  assign R2InEn        = dst_oh[REG_R2];
  assign R3InEn        = dst_oh[REG_R3];
  assign P0InEn        = dst_oh[REG_P0];
  assign MARin         = ctl[CTL_MARIN];
  assign MDR_frommemin = ctl[CTL_MDRFM];
  assign MDRout        = ctl[CTL_MDROUT];
  assign EN            = ctl[CTL_EN];
  assign RW            = ctl[CTL_RW];

endmodule

// File: tb/tb_load_fsm.sv
// Bench for load_fsm: two instances (MEM_WAIT=1 and 3) share stimulus and are
// compared every cycle against a cycle-count reference model.
module tb_load_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        donefetch = 1'b0;
  logic [5:0]  pdst = '0;
  logic [5:0]  paddr = '0;
  logic [17:0] v1, v3;
  int          checks = 0;
  int          failures = 0;

  // Model state per instance: index 0 -> MEM_WAIT=1, index 1 -> MEM_WAIT=3
  int mw[2] = '{1, 3};
  bit m_act[2];
  int m_t[2], m_dst[2], m_addr[2];

  always #5 clk = ~clk;

  load_fsm #(.SEL_W(6), .MEM_WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .donefetch(donefetch),
    .param_dst(pdst), .param_addr(paddr),
    .R0OutEn(v1[0]), .R1OutEn(v1[1]), .R2OutEn(v1[2]), .R3OutEn(v1[3]), .P0OutEn(v1[4]),
    .R0InEn(v1[5]), .R1InEn(v1[6]), .R2InEn(v1[7]), .R3InEn(v1[8]), .P0InEn(v1[9]),
    .MARin(v1[10]), .MDR_frommemin(v1[11]), .MDRout(v1[12]), .EN(v1[13]), .RW(v1[14]),
    .busy(v1[15]), .done(v1[16]), .err(v1[17])
  );

  load_fsm #(.SEL_W(6), .MEM_WAIT(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .donefetch(donefetch),
    .param_dst(pdst), .param_addr(paddr),
    .R0OutEn(v3[0]), .R1OutEn(v3[1]), .R2OutEn(v3[2]), .R3OutEn(v3[3]), .P0OutEn(v3[4]),
    .R0InEn(v3[5]), .R1InEn(v3[6]), .R2InEn(v3[7]), .R3InEn(v3[8]), .P0InEn(v3[9]),
    .MARin(v3[10]), .MDR_frommemin(v3[11]), .MDRout(v3[12]), .EN(v3[13]), .RW(v3[14]),
    .busy(v3[15]), .done(v3[16]), .err(v3[17])
  );

  // flags = {err,done,busy,rw,en,mdrout,mdrfm,marin}
  function automatic logic [17:0] mk(input logic [4:0] oe, input logic [4:0] ie, input logic [7:0] f);
    return {f, ie, oe};
  endfunction

  function automatic logic [17:0] model_exp(input int i);
    logic [4:0] oe = '0;
    logic [4:0] ie = '0;
    logic [7:0] f  = '0;
    int t = m_t[i];
    int w = mw[i];
    if (!m_act[i]) return '0;
    f[5] = 1'b1;
    if (m_dst[i] > 4 || m_addr[i] > 4) begin
      if (t == 2) f[7] = 1'b1;
    end else if (t == 2) begin
      oe[m_addr[i]] = 1'b1; f[0] = 1'b1;
    end else if (t >= 3 && t <= 2 + w) begin
      f[4] = 1'b1; f[3] = 1'b1;
    end else if (t == 3 + w) begin
      f[4] = 1'b1; f[3] = 1'b1; f[1] = 1'b1;
    end else if (t == 4 + w) begin
      f[2] = 1'b1; ie[m_dst[i]] = 1'b1;
    end else if (t == 5 + w) begin
      f[6] = 1'b1;
    end
    return mk(oe, ie, f);
  endfunction

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (rst || donefetch) m_act[i] = 1'b0;
      else if (!m_act[i]) begin
        if (start) begin
          m_act[i] = 1'b1; m_t[i] = 1; m_dst[i] = int'(pdst); m_addr[i] = int'(paddr);
        end
      end else begin
        int last = (m_dst[i] > 4 || m_addr[i] > 4) ? 2 : 5 + mw[i];
        if (m_t[i] == last) m_act[i] = 1'b0;
        else                m_t[i]++;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [17:0] v;
    for (int i = 0; i < 2; i++) begin
      v = (i == 0) ? v1 : v3;
      chk((i == 0) ? "model_mw1" : "model_mw3", v, model_exp(i));
      chk("onehot_outen", 18'($countones(v[4:0]) <= 1), 18'd1);
      chk("onehot_inen", 18'($countones(v[9:5]) <= 1), 18'd1);
      chk("outen_vs_mdrout", 18'((|v[4:0]) & v[12]), 18'd0);
      chk("en_implies_read", 18'(v[13] & ~v[14]), 18'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic quiet(input int n);
    rst = 1'b0; start = 1'b0; donefetch = 1'b0;
    for (int c = 0; c < n; c++) cycle();
  endtask

  typedef struct {
    bit          r;
    bit          s;
    bit          df;
    int          dst;
    int          addr;
    logic [17:0] exp;
  } row_t;

  row_t tbl[$];

  initial begin
    int done1_at, done3_at, err_at, maxrun, run, seen_bad, r0in, got1, got3;

    tbl.push_back('{1, 1, 0, 0, 0, '0});
    tbl.push_back('{1, 1, 0, 0, 0, '0});
    tbl.push_back('{0, 1, 0, 1, 2, mk(5'b00000, 5'b00000, 8'b0010_0000)});
    tbl.push_back('{0, 0, 0, 3, 3, mk(5'b00100, 5'b00000, 8'b0010_0001)});
    tbl.push_back('{0, 0, 0, 3, 3, mk(5'b00000, 5'b00000, 8'b0011_1000)});
    tbl.push_back('{0, 0, 0, 3, 3, mk(5'b00000, 5'b00000, 8'b0011_1010)});
    tbl.push_back('{0, 0, 0, 3, 3, mk(5'b00000, 5'b00010, 8'b0010_0100)});
    tbl.push_back('{0, 0, 0, 3, 3, mk(5'b00000, 5'b00000, 8'b0110_0000)});
    tbl.push_back('{0, 0, 0, 3, 3, '0});
    tbl.push_back('{0, 1, 0, 5, 0, mk(5'b00000, 5'b00000, 8'b0010_0000)});
    tbl.push_back('{0, 0, 0, 0, 0, mk(5'b00000, 5'b00000, 8'b1010_0000)});
    tbl.push_back('{0, 0, 0, 0, 0, '0});
    tbl.push_back('{0, 1, 0, 3, 3, mk(5'b00000, 5'b00000, 8'b0010_0000)});
    tbl.push_back('{0, 0, 0, 1, 1, mk(5'b01000, 5'b00000, 8'b0010_0001)});
    tbl.push_back('{0, 0, 0, 1, 1, mk(5'b00000, 5'b00000, 8'b0011_1000)});
    tbl.push_back('{0, 0, 0, 1, 1, mk(5'b00000, 5'b00000, 8'b0011_1010)});
    tbl.push_back('{0, 0, 0, 1, 1, mk(5'b00000, 5'b01000, 8'b0010_0100)});
    tbl.push_back('{0, 0, 0, 1, 1, mk(5'b00000, 5'b00000, 8'b0110_0000)});
    tbl.push_back('{0, 0, 0, 1, 1, '0});

    foreach (tbl[i]) begin
      rst = tbl[i].r; start = tbl[i].s; donefetch = tbl[i].df;
      pdst = 6'(tbl[i].dst); paddr = 6'(tbl[i].addr);
      cycle();
      chk($sformatf("table_row%0d", i), v1, tbl[i].exp);
    end
    quiet(8);

    // MEM_WAIT=3 with P0 as address source, R0 as destination
    done1_at = 0; done3_at = 0; maxrun = 0; run = 0; r0in = 0;
    paddr = 6'd4; pdst = 6'd0;
    for (int k = 1; k <= 12; k++) begin
      start = (k == 1);
      cycle();
      if (v3[13] && v3[14]) run++; else run = 0;
      if (run > maxrun) maxrun = run;
      if (v3[5]) r0in = 1;
      if (v1[16] && done1_at == 0) done1_at = k;
      if (v3[16] && done3_at == 0) done3_at = k;
    end
    chk("mw3_en_run", 18'(maxrun), 18'd4);
    chk("mw3_r0inen", 18'(r0in), 18'd1);
    chk("mw3_done_cycle", 18'(done3_at), 18'd8);
    chk("mw1_done_cycle", 18'(done1_at), 18'd6);
    quiet(3);

    // Illegal destination code
    err_at = 0; seen_bad = 0;
    pdst = 6'd5; paddr = 6'd1;
    for (int k = 1; k <= 6; k++) begin
      start = (k == 1);
      cycle();
      if (v1[17] && err_at == 0) err_at = k;
      if ((|v1[9:0]) || v1[10] || v1[13]) seen_bad = 1;
      if (k == 3) chk("illegal_busy_drop", 18'(v1[15]), 18'd0);
    end
    chk("illegal_err_cycle", 18'(err_at), 18'd2);
    chk("illegal_no_bus", 18'(seen_bad), 18'd0);
    quiet(3);

    // Abort during LATCH, then a fresh op
    pdst = 6'd1; paddr = 6'd2;
    for (int k = 1; k <= 4; k++) begin
      start = (k == 1);
      cycle();
    end
    chk("abort_in_latch", 18'(v1[11]), 18'd1);
    donefetch = 1'b1;
    cycle();
    chk("abort_outputs_zero", v1, '0);
    donefetch = 1'b0;
    got1 = 0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      got1 += int'(v1[16]);
    end
    chk("abort_no_done", 18'(got1), 18'd0);
    done1_at = 0;
    for (int k = 1; k <= 8; k++) begin
      start = (k == 1);
      cycle();
      if (v1[16] && done1_at == 0) done1_at = k;
    end
    chk("after_abort_done", 18'(done1_at), 18'd6);
    quiet(4);

    // Reset in the middle of RD, start held high during reset
    for (int k = 1; k <= 3; k++) begin
      start = (k == 1);
      cycle();
    end
    chk("rst_pre_rd", 18'(v1[13]), 18'd1);
    rst = 1'b1; start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("rst_zero_mw1", v1, '0);
      chk("rst_zero_mw3", v3, '0);
    end
    quiet(2);

    // start held high for 20 cycles with params changing every cycle
    got1 = 0; got3 = 0;
    for (int c = 0; c < 28; c++) begin
      start = (c < 20);
      pdst  = 6'($urandom_range(0, 4));
      paddr = 6'($urandom_range(0, 4));
      cycle();
      got1 += int'(v1[16]);
      got3 += int'(v3[16]);
    end
    chk("held_start_dones_mw1", 18'(got1), 18'd3);
    chk("held_start_dones_mw3", 18'(got3), 18'd3);
    quiet(3);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 63) == 0);
      donefetch = ($urandom_range(0, 15) == 0);
      start     = $urandom_range(0, 1);
      pdst      = 6'($urandom_range(0, 6));
      paddr     = 6'($urandom_range(0, 6));
      cycle();
    end
    quiet(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
